// File: rtl/bch_t3_pkg.sv
// bch_t3_pkg: shared constants, state enum and generator polynomial for the t=3 GF(2^10) BCH path
package bch_t3_pkg;

    localparam int GF_LEN       = 10;
    localparam int PAR_LEN      = 3 * GF_LEN;
    localparam int BCH_T3_K_MAX = 993;

    typedef enum logic [1:0] {ST_IDLE, ST_MSG, ST_PAR} state_e;

    // GF(2^10) multiply modulo x^10+x^3+1, MSB-first shift-and-add
    function automatic logic [9:0] gf_mul(input logic [9:0] a, input logic [9:0] b);
        logic [9:0] p;
        p = '0;
        for (int i = 9; i >= 0; i--) begin
            p = {p[8:0], 1'b0} ^ (p[9] ? 10'h009 : 10'h000);
            if (b[i]) p = p ^ a;
        end
        return p;
    endfunction

    // Minimal polynomial of alpha^e: product of (x + beta) over the 10 conjugates
    function automatic logic [10:0] min_poly(input int e);
        logic [10:0][9:0] c;
        logic [9:0]       beta;
        logic [10:0]      m;
        beta = 10'h001;
        for (int i = 0; i < e; i++) beta = gf_mul(beta, 10'h002);
        c    = '0;
        c[0] = 10'h001;
        for (int j = 0; j < GF_LEN; j++) begin
            for (int k = GF_LEN; k > 0; k--) c[k] = c[k-1] ^ gf_mul(c[k], beta);
            c[0] = gf_mul(c[0], beta);
            beta = gf_mul(beta, beta);
        end
        for (int k = 0; k <= GF_LEN; k++) m[k] = c[k][0];
        return m;
    endfunction

    // Generator g = m1 * m3 * m5 over GF(2), degree 30 (bit 30 set)
    function automatic logic [30:0] gen_poly();
        logic [30:0] g;
        logic [30:0] t;
        logic [10:0] m;
        g = 31'd1;
        for (int e = 1; e <= 5; e += 2) begin
            m = min_poly(e);
            t = '0;
            for (int k = 0; k <= GF_LEN; k++) if (m[k]) t = t ^ (g << k);
            g = t;
        end
        return g;
    endfunction

    localparam logic [30:0] BCH_T3_GEN_POLY = gen_poly();

endpackage

// File: rtl/bch_t3_enc_serial_if.sv
// bch_t3_enc_serial_if: bit-serial input/output handshake bundle; out_ready exists only with BCH_T3_ENC_BACKPRESSURE_EN
interface bch_t3_enc_serial_if;
    logic in_valid, in_ready, in_bit, in_sof;
    logic out_valid, out_bit, out_sof, out_eof, out_is_par;
`ifdef BCH_T3_ENC_BACKPRESSURE_EN
    logic out_ready;
    modport master (output in_valid, in_bit, in_sof, out_ready,
                    input  in_ready, out_valid, out_bit, out_sof, out_eof, out_is_par);
    modport slave  (input  in_valid, in_bit, in_sof, out_ready,
                    output in_ready, out_valid, out_bit, out_sof, out_eof, out_is_par);
`else
    modport master (output in_valid, in_bit, in_sof,
                    input  in_ready, out_valid, out_bit, out_sof, out_eof, out_is_par);
    modport slave  (input  in_valid, in_bit, in_sof,
                    output in_ready, out_valid, out_bit, out_sof, out_eof, out_is_par);
`endif
endinterface

// File: rtl/bch_t3_lfsr.sv
// bch_t3_lfsr: 30-bit remainder register; divides message by the generator, then unloads parity MSB first
module bch_t3_lfsr
    import bch_t3_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic shift_in,
    input  logic shift_out,
    input  logic din,
    output logic r_msb
);

    logic [PAR_LEN-1:0] r_q, r_d, base;
    logic               fb;

    // Division step on message bits (from zero when clr starts a frame), plain shift on parity unload
    always_comb begin
        base = clr ? '0 : r_q;
        fb   = din ^ base[PAR_LEN-1];
        r_d  = shift_in  ? ({base[PAR_LEN-2:0], 1'b0} ^ (fb ? BCH_T3_GEN_POLY[PAR_LEN-1:0] : '0)) :
               shift_out ? {r_q[PAR_LEN-2:0], 1'b0} : base;
    end

    // Remainder register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_q <= '0;
        else       r_q <= r_d;
    end

    assign r_msb = r_q[PAR_LEN-1];

endmodule

// File: rtl/bch_t3_enc_serial.sv
// bch_t3_enc_serial: bit-serial systematic t=3 BCH encoder; BCH_T3_ENC_BACKPRESSURE_EN adds out_ready stalling
module bch_t3_enc_serial
    import bch_t3_pkg::*;
#(
    parameter int K_LEN = BCH_T3_K_MAX
) (
    input logic                clk,
    input logic                rstn,
    bch_t3_enc_serial_if.slave bus
);

    localparam logic [9:0] K_LAST = 10'(K_LEN - 1);
    localparam logic [9:0] P_LAST = 10'(PAR_LEN - 1);

    state_e     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic       ov_q, ov_d, ob_q, ob_d, osof_q, osof_d, oeof_q, oeof_d, opar_q, opar_d;
    logic       ordy, out_adv, in_ready, acc, start, msg_acc, last_msg, par_go, last_par, r_msb;

`ifdef BCH_T3_ENC_BACKPRESSURE_EN
    assign ordy = bus.out_ready;
`else
    assign ordy = 1'b1;
`endif

    assign out_adv  = !ov_q | ordy;
    assign in_ready = (state_q != ST_PAR) & out_adv;
    assign acc      = bus.in_valid & in_ready;
    assign start    = acc & bus.in_sof & (state_q == ST_IDLE);
    assign msg_acc  = acc & (state_q == ST_MSG);
    assign last_msg = (start & (K_LEN == 1)) | (msg_acc & (cnt_q == K_LAST));
    assign par_go   = (state_q == ST_PAR) & out_adv;
    assign last_par = par_go & (cnt_q == P_LAST);

    // State, counter and output register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            ob_q    <= 1'b0;
            osof_q  <= 1'b0;
            oeof_q  <= 1'b0;
            opar_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            ob_q    <= ob_d;
            osof_q  <= osof_d;
            oeof_q  <= oeof_d;
            opar_q  <= opar_d;
        end
    end

    // Next state: sof opens a frame, K_LEN-th bit enters parity, 30th parity bit closes it
    always_comb begin
        state_d = last_par ? ST_IDLE : last_msg ? ST_PAR : start ? ST_MSG : state_q;
    end

    // Counter and output register next values; the register only moves when downstream can take it
    always_comb begin
        cnt_d  = (last_msg | last_par) ? '0 : start ? 10'd1 : (msg_acc | par_go) ? cnt_q + 10'd1 : cnt_q;
        ov_d   = out_adv ? (start | msg_acc | par_go) : ov_q;
        ob_d   = out_adv ? (par_go ? r_msb : bus.in_bit & (start | msg_acc)) : ob_q;
        osof_d = out_adv ? start : osof_q;
        oeof_d = out_adv ? last_par : oeof_q;
        opar_d = out_adv ? par_go : opar_q;
    end

    bch_t3_lfsr u_lfsr (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (start),
        .shift_in  (start | msg_acc),
        .shift_out (par_go),
        .din       (bus.in_bit),
        .r_msb     (r_msb)
    );

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = ov_q;
    assign bus.out_bit    = ob_q;
    assign bus.out_sof    = osof_q;
    assign bus.out_eof    = oeof_q;
    assign bus.out_is_par = opar_q;

endmodule
